// File: rtl/comb_sweep_pkg.sv
// Shared definitions for the combinational sweep checker.
//   - state_e  : FSM encoding (IDLE=0, RUN=1, DONE=2)
//   - bin2gray : binary-to-reflected-Gray mapping on a MAX_N_IN-bit index
package comb_sweep_pkg;

    localparam int unsigned MAX_N_IN = 16;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    function automatic logic [MAX_N_IN-1:0] bin2gray(input logic [MAX_N_IN-1:0] idx);
        return idx ^ (idx >> 1);
    endfunction

endpackage

// File: rtl/sweep_index_gen.sv
// Vector index generator for the sweep checker.
// Holds the sweep index, the per-vector hold counter, the latched sweep order
// and the registered vector driven to the DUT.
// Ports:
//   i_clk, i_rst   clock, asynchronous active-high reset
//   i_clear        accepted start: restart at vector 0 and latch i_gray_mode
//   i_gray_mode    sweep order for the next sweep (0 binary, 1 Gray)
//   i_run          advance enable (RUN and not aborting)
//   o_vec_out      vector currently driven to the DUT
//   o_sample       this edge samples the DUT output for o_vec_out
//   o_last         current index is the final vector of the sweep
module sweep_index_gen
    import comb_sweep_pkg::*;
#(
    parameter int unsigned N_IN        = 5,
    parameter int unsigned HOLD_CYCLES = 1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_clear,
    input  logic            i_gray_mode,
    input  logic            i_run,
    output logic [N_IN-1:0] o_vec_out,
    output logic            o_sample,
    output logic            o_last
);

    localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int unsigned IDX_W  = N_IN + 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'((1 << N_IN) - 1);

    logic              r_gray;
    logic [IDX_W-1:0]  r_idx;
    logic [HOLD_W-1:0] r_hold;
    logic [N_IN-1:0]   r_vec;
    logic [N_IN-1:0]   w_idx_next;
    logic [N_IN-1:0]   w_vec_next;

    // The index is one bit wider than a vector so the terminal compare never wraps;
    // only the low bits are ever mapped onto the DUT.
    assign w_idx_next = N_IN'(r_idx + 1'b1);
    assign w_vec_next = r_gray ? N_IN'(bin2gray(MAX_N_IN'(w_idx_next))) : w_idx_next;

    assign o_sample  = i_run && (r_hold == HOLD_LAST);
    assign o_last    = (r_idx == IDX_LAST);
    assign o_vec_out = r_vec;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_gray <= 1'b0;
            r_idx  <= '0;
            r_hold <= '0;
            r_vec  <= '0;
        end else if (i_clear) begin
            r_gray <= i_gray_mode;
            r_idx  <= '0;
            r_hold <= '0;
            r_vec  <= '0;
        end else if (i_run) begin
            if (r_hold == HOLD_LAST) begin
                r_hold <= '0;
                // On the last vector the index stays put so vec_out holds it in DONE.
                if (!o_last) begin
                    r_idx <= r_idx + 1'b1;
                    r_vec <= w_vec_next;
                end
            end else begin
                r_hold <= r_hold + 1'b1;
            end
        end
    end

endmodule

// File: rtl/comb_sweep_checker.sv
// Exhaustive self-checking stimulus engine for an N_IN-input combinational block.
// Sweeps all 2^N_IN vectors (binary or Gray order), holds each for HOLD_CYCLES
// clocks, compares the DUT output against TRUTH_TABLE and reports the results.
// Ports:
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_start               start request, accepted in IDLE or DONE
//   i_gray_mode           sweep order latched on an accepted start
//   i_abort               return to IDLE; wins over start and the last sample
//   i_dut_f               DUT output for o_vec_out
//   o_vec_out             vector driven to the DUT (MSB = first DUT input)
//   o_busy, o_done        RUN / DONE status levels
//   o_pass                DONE with zero mismatches
//   o_err_cnt             saturating mismatch count
//   o_first_err_valid     a mismatch has been captured this sweep
//   o_first_err_vec       vector of the first mismatch
module comb_sweep_checker
    import comb_sweep_pkg::*;
#(
    parameter int unsigned            N_IN        = 5,
    parameter logic [2**N_IN-1:0]     TRUTH_TABLE = '0,
    parameter int unsigned            HOLD_CYCLES = 1,
    parameter int unsigned            ERR_W       = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_gray_mode,
    input  logic             i_abort,
    input  logic             i_dut_f,
    output logic [N_IN-1:0]  o_vec_out,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_pass,
    output logic [ERR_W-1:0] o_err_cnt,
    output logic             o_first_err_valid,
    output logic [N_IN-1:0]  o_first_err_vec
);

    state_e           r_state;
    state_e           w_state_d;
    logic             w_start_acc;
    logic             w_run;
    logic             w_sample;
    logic             w_last;
    logic             w_mismatch;
    logic [ERR_W-1:0] r_err_cnt;
    logic             r_first_valid;
    logic [N_IN-1:0]  r_first_vec;

    // An abort cycle neither samples nor advances the sweep.
    assign w_run = (r_state == StRun) && !i_abort;

    sweep_index_gen #(
        .N_IN        (N_IN),
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_index_gen (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_clear     (w_start_acc),
        .i_gray_mode (i_gray_mode),
        .i_run       (w_run),
        .o_vec_out   (o_vec_out),
        .o_sample    (w_sample),
        .o_last      (w_last)
    );

    assign w_mismatch = w_sample && (i_dut_f != TRUTH_TABLE[o_vec_out]);

    always_comb begin
        w_state_d   = r_state;
        w_start_acc = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (i_start && !i_abort) begin
                    w_state_d   = StRun;
                    w_start_acc = 1'b1;
                end
            end
            StRun: begin
                if (i_abort) begin
                    w_state_d = StIdle;
                end else if (w_sample && w_last) begin
                    w_state_d = StDone;
                end
            end
            StDone: begin
                if (i_abort) begin
                    w_state_d = StIdle;
                end else if (i_start) begin
                    w_state_d   = StRun;
                    w_start_acc = 1'b1;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_err_cnt     <= '0;
            r_first_valid <= 1'b0;
            r_first_vec   <= '0;
        end else if (w_start_acc) begin
            r_err_cnt     <= '0;
            r_first_valid <= 1'b0;
            r_first_vec   <= '0;
        end else if (w_mismatch) begin
            if (!(&r_err_cnt)) begin
                r_err_cnt <= r_err_cnt + 1'b1;
            end
            if (!r_first_valid) begin
                r_first_valid <= 1'b1;
                r_first_vec   <= o_vec_out;
            end
        end
    end

    always_comb begin
        o_busy = (r_state == StRun);
        o_done = (r_state == StDone);
        o_pass = (r_state == StDone) && (r_err_cnt == '0);
    end

    assign o_err_cnt         = r_err_cnt;
    assign o_first_err_valid = r_first_valid;
    assign o_first_err_vec   = r_first_vec;

endmodule

// File: tb/tb_comb_sweep_checker.sv
module tb_comb_sweep_checker;

    typedef struct {
        int         inst;      // 0: HOLD=1/ERR_W=8, 1: HOLD=3/ERR_W=3
        logic       gray;
        int         mode;      // 0 correct DUT, 1 stuck-at-0, 2 inverted
        int         hold;
        int         exp_err;
        logic       exp_valid;
        int         exp_first;
        logic       exp_pass;
        int         exp_last;
    } row_t;

    logic [31:0] tt = 32'hFFFF0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic a_start = 1'b0, a_gray = 1'b0, a_abort = 1'b0;
    logic b_start = 1'b0, b_gray = 1'b0, b_abort = 1'b0;
    int   a_mode = 0, b_mode = 0;
    int   sel = 0;

    logic [4:0] a_vec, a_first, b_vec, b_first;
    logic       a_busy, a_done, a_pass, a_valid, a_f;
    logic       b_busy, b_done, b_pass, b_valid, b_f;
    logic [7:0] a_err;
    logic [2:0] b_err;

    int checks = 0;
    int errors = 0;

    function automatic logic model_f(input int mode, input logic [31:0] t, input logic [4:0] v);
        if (mode == 0) return t[v];
        if (mode == 1) return 1'b0;
        return ~t[v];
    endfunction

    function automatic logic [4:0] mapv(input int i, input logic g);
        logic [4:0] b;
        b = 5'(i);
        return g ? (b ^ (b >> 1)) : b;
    endfunction

    assign a_f = model_f(a_mode, tt, a_vec);
    assign b_f = model_f(b_mode, tt, b_vec);

    comb_sweep_checker #(
        .N_IN        (5),
        .TRUTH_TABLE (32'hFFFF0000),
        .HOLD_CYCLES (1),
        .ERR_W       (8)
    ) u_dut_a (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_start           (a_start),
        .i_gray_mode       (a_gray),
        .i_abort           (a_abort),
        .i_dut_f           (a_f),
        .o_vec_out         (a_vec),
        .o_busy            (a_busy),
        .o_done            (a_done),
        .o_pass            (a_pass),
        .o_err_cnt         (a_err),
        .o_first_err_valid (a_valid),
        .o_first_err_vec   (a_first)
    );

    comb_sweep_checker #(
        .N_IN        (5),
        .TRUTH_TABLE (32'hFFFF0000),
        .HOLD_CYCLES (3),
        .ERR_W       (3)
    ) u_dut_b (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_start           (b_start),
        .i_gray_mode       (b_gray),
        .i_abort           (b_abort),
        .i_dut_f           (b_f),
        .o_vec_out         (b_vec),
        .o_busy            (b_busy),
        .o_done            (b_done),
        .o_pass            (b_pass),
        .o_err_cnt         (b_err),
        .o_first_err_valid (b_valid),
        .o_first_err_vec   (b_first)
    );

    // Outputs of the instance currently under test.
    logic       s_busy, s_done, s_pass, s_valid;
    logic [4:0] s_vec, s_first;
    logic [7:0] s_err;
    always_comb begin
        if (sel == 0) begin
            s_busy = a_busy; s_done = a_done; s_pass = a_pass; s_valid = a_valid;
            s_vec = a_vec; s_first = a_first; s_err = a_err;
        end else begin
            s_busy = b_busy; s_done = b_done; s_pass = b_pass; s_valid = b_valid;
            s_vec = b_vec; s_first = b_first; s_err = 8'(b_err);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic pulse_start(input logic gray);
        if (sel == 0) begin a_gray = gray; a_start = 1'b1; end
        else begin b_gray = gray; b_start = 1'b1; end
        @(negedge clk);
        a_start = 1'b0;
        b_start = 1'b0;
    endtask

    task automatic pulse_abort();
        if (sel == 0) a_abort = 1'b1;
        else b_abort = 1'b1;
        @(negedge clk);
        a_abort = 1'b0;
        b_abort = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " busy"}, int'(s_busy), 0);
        check({tag, " done"}, int'(s_done), 0);
        check({tag, " pass"}, int'(s_pass), 0);
        check({tag, " err"}, int'(s_err), 0);
        check({tag, " valid"}, int'(s_valid), 0);
        check({tag, " first"}, int'(s_first), 0);
        check({tag, " vec"}, int'(s_vec), 0);
    endtask

    task automatic run_row(input int n, input row_t r);
        string t;
        t = $sformatf("row%0d", n);
        sel = r.inst;
        if (r.inst == 0) a_mode = r.mode;
        else b_mode = r.mode;
        @(negedge clk);
        pulse_start(r.gray);
        for (int k = 0; k < 32 * r.hold; k++) begin
            if (k == 0) begin
                check({t, " done drop"}, int'(s_done), 0);
                check({t, " pass drop"}, int'(s_pass), 0);
            end
            check($sformatf("%s busy k%0d", t, k), int'(s_busy), 1);
            check($sformatf("%s vec k%0d", t, k), int'(s_vec), int'(mapv(k / r.hold, r.gray)));
            @(negedge clk);
        end
        check({t, " busy end"}, int'(s_busy), 0);
        check({t, " done"}, int'(s_done), 1);
        check({t, " pass"}, int'(s_pass), int'(r.exp_pass));
        check({t, " err"}, int'(s_err), r.exp_err);
        check({t, " valid"}, int'(s_valid), int'(r.exp_valid));
        check({t, " first"}, int'(s_first), r.exp_first);
        check({t, " last vec"}, int'(s_vec), r.exp_last);
    endtask

    row_t rows[8];

    initial begin
        rows[0] = '{0, 1'b0, 0, 1,  0, 1'b0,  0, 1'b1, 31};
        rows[1] = '{0, 1'b0, 1, 1, 16, 1'b1, 16, 1'b0, 31};
        rows[2] = '{0, 1'b0, 2, 1, 32, 1'b1,  0, 1'b0, 31};
        rows[3] = '{0, 1'b1, 0, 1,  0, 1'b0,  0, 1'b1, 16};
        rows[4] = '{0, 1'b1, 1, 1, 16, 1'b1, 24, 1'b0, 16};
        rows[5] = '{1, 1'b1, 0, 3,  0, 1'b0,  0, 1'b1, 16};
        rows[6] = '{1, 1'b0, 2, 3,  7, 1'b1,  0, 1'b0, 31};
        rows[7] = '{1, 1'b1, 1, 3,  7, 1'b1, 24, 1'b0, 16};

        // Reset state of both instances.
        #1;
        sel = 0; #0; check_all_zero("reset a");
        sel = 1; #0; check_all_zero("reset b");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) run_row(i, rows[i]);

        // Abort at idx 10 with an inverted DUT; start during RUN must be ignored.
        sel = 0;
        a_mode = 2;
        @(negedge clk);
        pulse_start(1'b0);
        for (int k = 0; k <= 10; k++) begin
            check($sformatf("abort vec k%0d", k), int'(s_vec), k);
            if (k == 5) a_start = 1'b1;
            if (k == 6) a_start = 1'b0;
            if (k < 10) @(negedge clk);
        end
        pulse_abort();
        check("abort busy", int'(s_busy), 0);
        check("abort done", int'(s_done), 0);
        check("abort pass", int'(s_pass), 0);
        check("abort err kept", int'(s_err), 10);
        check("abort valid kept", int'(s_valid), 1);
        check("abort first kept", int'(s_first), 0);
        @(negedge clk);
        check("abort idle busy", int'(s_busy), 0);

        // Asynchronous reset mid-sweep at idx 20.
        pulse_start(1'b0);
        for (int k = 0; k < 20; k++) @(negedge clk);
        check("pre-rst vec", int'(s_vec), 20);
        check("pre-rst err", int'(s_err), 20);
        #2 rst = 1'b1;
        #1 check_all_zero("mid rst");
        @(negedge clk);
        rst = 1'b0;
        run_row(8, rows[0]);

        // Abort out of DONE.
        pulse_abort();
        check("done abort done", int'(s_done), 0);
        check("done abort pass", int'(s_pass), 0);
        check("done abort busy", int'(s_busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
